rom_sequencer: RTL

- Program store and instruction sequencer that serves the `rom_inst` / `rom_done` / `inst_done` interface of the 4-bit CPU controller.
- Holds a small writable program of 8-bit instructions.
- On start, presents instructions in address order, advancing one word per `inst_done` pulse, and raises `rom_done` once the program is exhausted.
- Sits between the user input path (program loading) and the CPU controller (run mode).

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/prog_mem.sv | 30 +++
 rtl/rom_sequencer.sv | 103 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit CPU: instruction layout, opcodes and
// the sequencer state encoding used by the program store.
package cpu_pkg;

   localparam int INST_W = 8;

   localparam logic [1:0] OP_LOAD = 2'd0;
   localparam logic [1:0] OP_STR  = 2'd1;
   localparam logic [1:0] OP_MV   = 2'd2;
   localparam logic [1:0] OP_ALU  = 2'd3;

   // Bit positions of the instruction fields
   localparam int OPC_HI   = 7;
   localparam int OPC_LO   = 6;
   localparam int RX_HI    = 5;
   localparam int RX_LO    = 4;
   localparam int RY_HI    = 3;
   localparam int RY_LO    = 2;
   localparam int DATA_HI  = 3;
   localparam int DATA_LO  = 0;
   localparam int FUNCT_HI = 1;
   localparam int FUNCT_LO = 0;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_RUN  = 1'b1
   } seq_state_t;

   function automatic logic [1:0] inst_opcode(input logic [INST_W-1:0] inst);
      return inst[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/prog_mem.sv
// Program word store: synchronous write, registered read. A write to the
// address being read is forwarded so the read port always sees current data.
module prog_mem
   import cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [INST_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [INST_W-1:0] rdata
);

   logic [INST_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (we && (waddr == raddr)) begin
         rdata <= wdata;
      end else begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/rom_sequencer.sv
// Writable program store plus sequencer: loads words in IDLE, then presents
// them in address order during RUN, advancing one word per inst_done.
module rom_sequencer
   import cpu_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              prog_clear,
   input  logic              prog_we,
   input  logic [INST_W-1:0] prog_data,
   input  logic              start,
   input  logic              inst_done,
   output logic [INST_W-1:0] rom_inst,
   output logic              rom_done,
   output logic [AW:0]       pc,
   output logic [AW:0]       len,
   output logic              full,
   output logic              busy
);

   localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

   seq_state_t        state_reg, state_next;
   logic [AW:0]       pc_reg, pc_next;
   logic [AW:0]       len_reg, len_next;
   logic              inst_valid_reg;
   logic              mem_we;
   logic [AW-1:0]     mem_raddr;
   logic [INST_W-1:0] mem_rdata;
   logic              full_int;

   assign full_int = (len_reg == DEPTH_V);

   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      len_next   = len_reg;
      mem_we     = 1'b0;
      if (state_reg == SEQ_IDLE) begin
         if (start) begin
            state_next = SEQ_RUN;
            pc_next    = '0;
         end else if (prog_clear) begin
            len_next = '0;
         end else if (prog_we && !full_int) begin
            mem_we   = 1'b1;
            len_next = len_reg + 1'b1;
         end
      end else begin
         // Restart beats everything; an exhausted program drops back to IDLE
         if (start) begin
            pc_next = '0;
         end else if (pc_reg >= len_reg) begin
            state_next = SEQ_IDLE;
         end else if (inst_done) begin
            pc_next = pc_reg + 1'b1;
            if ((pc_reg + 1'b1) == len_reg) begin
               state_next = SEQ_IDLE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state_reg      <= SEQ_IDLE;
         pc_reg         <= '0;
         len_reg        <= '0;
         inst_valid_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         pc_reg         <= pc_next;
         len_reg        <= len_next;
         inst_valid_reg <= (pc_next < len_next);
      end
   end

   // Reading at the next pc makes rom_inst track mem[pc] with no extra cycle
   assign mem_raddr = (pc_next < DEPTH_V) ? pc_next[AW-1:0] : '0;

   prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_prog_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (len_reg[AW-1:0]),
      .wdata (prog_data),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   assign rom_inst = inst_valid_reg ? mem_rdata : '0;
   assign rom_done = (state_reg == SEQ_IDLE) || (pc_reg >= len_reg);
   assign pc       = pc_reg;
   assign len      = len_reg;
   assign full     = full_int;
   assign busy     = (state_reg == SEQ_RUN);

endmodule
